// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

    // Width of the saturating dropped-packet counter.
    localparam int unsigned DropCntW = 8;

    // Packet-level routing state.
    typedef enum logic [1:0] {
        StIdle,   // no packet open
        StRoute,  // packet open, legal channel locked
        StDrop    // packet open, illegal channel, beats discarded
    } state_e;

    // Channel index width: max(1, clog2(n)).
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry output register slice: holds one {last, data} beat plus its channel index.
module stream_reg_slice #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CH_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,     // capture a new beat
    input  logic [DATA_W:0]   payload_i,  // {last, data}
    input  logic [CH_W-1:0]   ch_i,
    input  logic              taken_i,    // held beat accepted downstream this cycle
    output logic              valid_o,
    output logic [DATA_W:0]   payload_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              free_o      // slice can take a beat this cycle
);

    logic              valid_q, valid_d;
    logic [DATA_W:0]   payload_q;
    logic [CH_W-1:0]   ch_q;

    // Occupancy: a load wins over a drain so simultaneous drain+load keeps the slice full.
    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (taken_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; payload and channel only change on load so they hold during a stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ch_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                payload_q <= payload_i;
                ch_q      <= ch_i;
            end
        end
    end

    assign free_o    = !valid_q || taken_i;
    assign valid_o   = valid_q;
    assign payload_o = payload_q;
    assign ch_o      = ch_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// 1-to-N packet demultiplexer: the first beat's sel locks the destination for the whole
// packet; packets addressed to a nonexistent channel are swallowed and counted.
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  N_CH   = 16,
    localparam int unsigned SEL_W  = sel_width(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   din,
    input  logic [SEL_W-1:0]    sel,
    input  logic                s_last,
    output logic [DATA_W-1:0]   dout,
    output logic [N_CH-1:0]     m_valid,
    output logic                m_last,
    input  logic [N_CH-1:0]     m_ready,
    output logic [DropCntW-1:0] drop_cnt
);

    state_e                state_q, state_d;
    logic [DropCntW-1:0]   drop_q, drop_d;

    logic                  out_v;
    logic [DATA_W:0]       out_payload;
    logic [SEL_W-1:0]      ch_q;
    logic                  slice_free;
    logic                  held_ready;
    logic                  load;
    logic                  accept;
    logic                  sel_ok;

    // One extra bit so N_CH itself is representable when N_CH is a power of two.
    assign sel_ok = {1'b0, sel} < (SEL_W + 1)'(N_CH);

    // Only the held channel's ready matters; other channels' ready bits are masked off.
    assign held_ready = |(m_valid & m_ready);
    assign accept     = s_valid && s_ready;

    // Input ready: DROP sinks freely, otherwise wait for room in the slice; never during reset.
    always_comb begin
        s_ready = slice_free;
        if (state_q == StDrop) begin
            s_ready = 1'b1;
        end
        if (rst) begin
            s_ready = 1'b0;
        end
    end

    // Packet FSM next state, slice load and drop counting.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (sel_ok) begin
                        load = 1'b1;
                        if (!s_last) state_d = StRoute;
                    end else begin
                        if (drop_q != '1) drop_d = drop_q + DropCntW'(1);
                        if (!s_last) state_d = StDrop;
                    end
                end
            end
            StRoute: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_last) state_d = StIdle;
                end
            end
            StDrop: begin
                if (accept && s_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // In ROUTE the slice keeps the channel latched on the first beat, so sel is ignored.
    logic [SEL_W-1:0] load_ch;
    assign load_ch = (state_q == StIdle) ? sel : ch_q;

    stream_reg_slice #(
        .DATA_W (DATA_W),
        .CH_W   (SEL_W)
    ) u_slice (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .payload_i ({s_last, din}),
        .ch_i      (load_ch),
        .taken_i   (held_ready),
        .valid_o   (out_v),
        .payload_o (out_payload),
        .ch_o      (ch_q),
        .free_o    (slice_free)
    );

    // Decode the held channel into the one-hot-or-zero valid vector.
    always_comb begin
        m_valid = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            m_valid[i] = out_v && (ch_q == SEL_W'(i));
        end
    end

    assign dout     = out_payload[DATA_W-1:0];
    assign m_last   = out_payload[DATA_W];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton with 10 channels so illegal sel values exist.
module tb_stream_demux_1ton;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 10;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] din;
    logic [SW-1:0] sel;
    logic          s_last;
    logic [DW-1:0] dout;
    logic [NC-1:0] m_valid;
    logic          m_last;
    logic [NC-1:0] m_ready;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    stream_demux_1ton #(
        .DATA_W (DW),
        .N_CH   (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .din      (din),
        .sel      (sel),
        .s_last   (s_last),
        .dout     (dout),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .drop_cnt (drop_cnt)
    );

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one beat, wait for acceptance, push the expected output (exp_ch < 0: dropped).
    // Every beat in this bench is expected to be taken on the first offered cycle.
    task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic l,
                        input int exp_ch);
        int   waits;
        logic acc;
        waits   = 0;
        acc     = 1'b0;
        s_valid = 1'b1;
        sel     = s;
        din     = d;
        s_last  = l;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL accept_timeout din=%0h waited=%0d required=0", d, waits);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        if (exp_ch >= 0) begin
            exp_q.push_back('{ch: exp_ch[SW-1:0], data: d, last: l});
        end
        s_valid = 1'b0;
        check("accept_wait", waits, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream handshake pops the scoreboard and compares.
    always @(negedge clk) begin : mon
        beat_t e;
        n_tests++;
        if ($countones(m_valid) > 1) begin
            n_fail++;
            $display("FAIL onehot m_valid=%0h required at most one bit", m_valid);
        end
        for (int i = 0; i < int'(NC); i++) begin
            if (m_valid[i] && m_ready[i]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat ch=%0d dout=%0h required=no beat", i, dout);
                end else begin
                    e = exp_q.pop_front();
                    if (i != int'(e.ch) || dout !== e.data || m_last !== e.last) begin
                        n_fail++;
                        $display("FAIL beat ch=%0d dout=%0h last=%0b required ch=%0d dout=%0h last=%0b",
                                 i, dout, m_last, e.ch, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        din     = '0;
        sel     = '0;
        s_last  = 1'b0;
        m_ready = '1;

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_m_last", m_last, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Single-beat packet, one-cycle latency
        send(4'd5, 8'hA5, 1'b1, 5);
        @(negedge clk);
        check("single_m_valid", m_valid, 10'h020);
        check("single_dout", dout, 8'hA5);
        check("single_m_last", m_last, 1);
        idle(1);

        // Mid-packet sel change ignored; FSM back in IDLE afterwards
        send(4'd3, 8'h10, 1'b0, 3);
        send(4'd9, 8'h11, 1'b0, 3);
        send(4'd9, 8'h12, 1'b0, 3);
        send(4'd9, 8'h13, 1'b1, 3);
        send(4'd6, 8'h14, 1'b1, 6);

        // Back-to-back packets to different channels
        send(4'd2, 8'h20, 1'b0, 2);
        send(4'd2, 8'h21, 1'b1, 2);
        send(4'd4, 8'h22, 1'b0, 4);
        send(4'd4, 8'h23, 1'b1, 4);
        idle(2);

        // Only the selected channel's ready matters
        m_ready = 10'h100;
        send(4'd8, 8'h30, 1'b0, 8);
        send(4'd0, 8'h31, 1'b1, 8);
        idle(2);
        m_ready = '1;
        idle(1);

        // Backpressure on channel 7 with every other channel ready
        m_ready = ~10'h080;
        send(4'd7, 8'h40, 1'b0, 7);
        s_valid = 1'b1;
        sel     = 4'd7;
        din     = 8'h41;
        s_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_ready", s_ready, 0);
            check("stall_dout", dout, 8'h40);
            check("stall_m_valid", m_valid, 10'h080);
            @(posedge clk);
            #1;
        end
        m_ready = '1;
        send(4'd7, 8'h41, 1'b0, 7);
        send(4'd7, 8'h42, 1'b1, 7);
        idle(2);

        // New packet for another channel blocked behind a stalled beat
        m_ready = ~10'h004;
        send(4'd2, 8'h50, 1'b1, 2);
        s_valid = 1'b1;
        sel     = 4'd4;
        din     = 8'h51;
        s_last  = 1'b1;
        @(negedge clk);
        check("other_ch_block", s_ready, 0);
        check("other_ch_m_valid", m_valid, 10'h004);
        @(posedge clk);
        #1;
        m_ready = '1;
        send(4'd4, 8'h51, 1'b1, 4);
        idle(3);

        // Illegal channel: packet dropped, counter saturates
        check("drop_init", drop_cnt, 0);
        send(4'd12, 8'h60, 1'b0, -1);
        check("drop_first_beat", drop_cnt, 1);
        send(4'd3, 8'h61, 1'b0, -1);
        send(4'd3, 8'h62, 1'b1, -1);
        check("drop_one_pkt", drop_cnt, 1);
        for (int p = 1; p < 300; p++) begin
            send(4'd12, 8'h63, 1'b0, -1);
            send(4'd12, 8'h64, 1'b0, -1);
            send(4'd12, 8'h65, 1'b1, -1);
            if (p == 254) check("drop_255", drop_cnt, 255);
        end
        check("drop_saturate", drop_cnt, 255);
        idle(2);

        // Reset in the middle of a packet
        send(4'd6, 8'h70, 1'b0, 6);
        send(4'd6, 8'h71, 1'b0, 6);
        s_valid = 1'b1;
        sel     = 4'd6;
        din     = 8'h72;
        s_last  = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("rst_mid_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_m_valid", m_valid, 0);
        check("rst_mid_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;
        send(4'd1, 8'h80, 1'b0, 1);
        send(4'd5, 8'h81, 1'b1, 1);

        idle(4);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
